// File: rtl/mux4to1_ser_pkg.sv
// Shared constants and FSM state type for the 4-lane byte serializer.
package mux4to1_ser_pkg;
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;
endpackage

// File: rtl/mux4to1_ser_lane_hold3.sv
// Holding registers for lanes 1..3 of an accepted word; loaded on transfer,
// cleared asynchronously by the active-low reset.
module lane_hold3 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_i,
  input  logic [DW-1:0] in1_i,
  input  logic [DW-1:0] in2_i,
  input  logic [DW-1:0] in3_i,
  output logic [DW-1:0] lane1_o,
  output logic [DW-1:0] lane2_o,
  output logic [DW-1:0] lane3_o
);
  logic [DW-1:0] lane1_q, lane2_q, lane3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane1_q <= '0;
      lane2_q <= '0;
      lane3_q <= '0;
    end else if (ld_i) begin
      lane1_q <= in1_i;
      lane2_q <= in2_i;
      lane3_q <= in3_i;
    end
  end

  assign lane1_o = lane1_q;
  assign lane2_o = lane2_q;
  assign lane3_o = lane3_q;
endmodule

// File: rtl/mux4to1_ser.sv
// 4-lane to byte-stream serializer, in0 emitted first, one byte per clock.
// Optional registered even-parity output enabled by MUX4TO1_SER_PARITY_EN.
//
// state | meaning
// IDLE  | nothing on output, ready for a word
// SEND  | lanes being emitted; cnt_q = lane currently on out_data
import mux4to1_ser_pkg::*;

module mux4to1_ser #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid
`ifdef MUX4TO1_SER_PARITY_EN
  ,
  output logic          out_parity
`endif
);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NUM_LANES - 1);

  state_t          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]   out_data_q;
  logic            out_valid_q;
  logic [DW-1:0]   lane_d;
  logic [DW-1:0]   lane1, lane2, lane3;
  logic            xfer;

  // Ready while idle or while the last lane is on the output, so a new word
  // follows lane 3 with no bubble; forced low while reset is held.
  assign in_ready = reset & ((state_q == IDLE) ||
                             ((state_q == SEND) && (cnt_q == LAST_LANE)));
  assign xfer     = in_valid & in_ready;

  lane_hold3 #(.DW(DW)) u_hold (
    .clk     (clk),
    .rst_n   (reset),
    .ld_i    (xfer),
    .in1_i   (in1),
    .in2_i   (in2),
    .in3_i   (in3),
    .lane1_o (lane1),
    .lane2_o (lane2),
    .lane3_o (lane3)
  );

  always_comb begin
    lane_d = lane3;
    case (cnt_q)
      2'd0:    lane_d = lane1;
      2'd1:    lane_d = lane2;
      default: lane_d = lane3;
    endcase
  end

`ifdef MUX4TO1_SER_PARITY_EN
  logic out_parity_q;
  assign out_parity = out_parity_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MUX4TO1_SER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else if (xfer) begin
      state_q     <= SEND;
      cnt_q       <= '0;
      out_data_q  <= in0;
      out_valid_q <= 1'b1;
`ifdef MUX4TO1_SER_PARITY_EN
      out_parity_q <= ^in0;
`endif
    end else if ((state_q == SEND) && (cnt_q != LAST_LANE)) begin
      cnt_q       <= cnt_q + 1'b1;
      out_data_q  <= lane_d;
      out_valid_q <= 1'b1;
`ifdef MUX4TO1_SER_PARITY_EN
      out_parity_q <= ^lane_d;
`endif
    end else begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MUX4TO1_SER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
endmodule
